// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, state encoding and word helpers for the
// AES-128 inverse key schedule.
//   NR      - number of AES rounds (AES-128 only)
//   KW      - key / round-key width in bits
//   state_t - controller states {IDLE, EXPAND, READY}
//   rcon    - round index (1..10) -> round constant byte
//   rot_word, xor_word - 32-bit word helpers used by the schedule step
package aes_pkg;

    localparam int NR = 10;
    localparam int KW = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // Round constant; only indices 1..10 are meaningful, the rest return 0.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Cyclic left rotation by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] xor_word(input logic [31:0] a, input logic [31:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
//   din  - input byte
//   dout - SubBytes(din)
// The table is derived from its definition (GF(2^8) inverse followed by the
// affine transform) so there is no hand-typed 256-entry table to get wrong.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] acc;
        s   = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s   = gf_mul(s, s);
            acc = gf_mul(acc, s);
        end
        return acc;
    endfunction

    logic [7:0] inv_s;

    // Inverse then affine transform.
    always_comb begin
        inv_s = gf_inv(din);
        dout  = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
              ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: round-key source for an iterative AES-128 decryptor.
// Expands the cipher key forward to round key 10 (one round per cycle), then
// walks back down to round key 0 on request using the inverse recurrence.
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   key_load  - sample key_in and (re)start expansion
//   key_in    - 128-bit cipher key, byte 0 in bits 127:120
//   rk_req    - step to the next lower round key (READY only)
//   rk_rewind - jump back to round key 10 (READY only)
//   busy      - expansion in progress
//   rk_valid  - rk_out / rk_round are meaningful
//   rk_out    - current round key
//   rk_round  - index of rk_out
//   rk_last   - rk_valid and rk_round == 0
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          key_load,
    input  logic [KW-1:0] key_in,
    input  logic          rk_req,
    input  logic          rk_rewind,
    output logic          busy,
    output logic          rk_valid,
    output logic [KW-1:0] rk_out,
    output logic [3:0]    rk_round,
    output logic          rk_last
);

    state_t        state_r, state_s;
    logic [KW-1:0] k10_r, k10_s;
    logic [KW-1:0] rk_s;
    logic [3:0]    round_s;
    logic          busy_s, valid_s, last_s;

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] sbox_in_s, rot_s, sub_s;
    logic [31:0] f0_s, f1_s, f2_s, f3_s;
    logic [31:0] i0_s, i1_s, i2_s, i3_s;

    assign w0_s = rk_out[127:96];
    assign w1_s = rk_out[95:64];
    assign w2_s = rk_out[63:32];
    assign w3_s = rk_out[31:0];

    // Shared S-box word path: forward uses w3, inverse needs the previous
    // key's last word, which is recovered as w7 ^ w6.
    always_comb begin
        if (state_r == READY) begin
            sbox_in_s = xor_word(w3_s, w2_s);
        end else begin
            sbox_in_s = w3_s;
        end
        rot_s = rot_word(sbox_in_s);
    end

    aes_sbox u_sbox3 (.din(rot_s[31:24]), .dout(sub_s[31:24]));
    aes_sbox u_sbox2 (.din(rot_s[23:16]), .dout(sub_s[23:16]));
    aes_sbox u_sbox1 (.din(rot_s[15:8]),  .dout(sub_s[15:8]));
    aes_sbox u_sbox0 (.din(rot_s[7:0]),   .dout(sub_s[7:0]));

    // Forward step (produces round rk_round+1) and inverse step (produces
    // round rk_round-1, using the Rcon of the key being undone).
    always_comb begin
        f0_s = xor_word(xor_word(w0_s, sub_s), {rcon(rk_round + 4'd1), 24'h000000});
        f1_s = xor_word(w1_s, f0_s);
        f2_s = xor_word(w2_s, f1_s);
        f3_s = xor_word(w3_s, f2_s);
        i3_s = xor_word(w3_s, w2_s);
        i2_s = xor_word(w2_s, w1_s);
        i1_s = xor_word(w1_s, w0_s);
        i0_s = xor_word(xor_word(w0_s, sub_s), {rcon(rk_round), 24'h000000});
    end

    // Next-state and next-output logic; key_load > rk_rewind > rk_req.
    always_comb begin
        state_s = state_r;
        k10_s   = k10_r;
        rk_s    = rk_out;
        round_s = rk_round;
        busy_s  = busy;
        valid_s = rk_valid;
        if (key_load) begin
            rk_s    = key_in;
            round_s = 4'd0;
            busy_s  = 1'b1;
            valid_s = 1'b0;
            state_s = EXPAND;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                EXPAND: begin
                    rk_s    = {f0_s, f1_s, f2_s, f3_s};
                    round_s = rk_round + 4'd1;
                    if (rk_round == 4'(NR - 1)) begin
                        k10_s   = {f0_s, f1_s, f2_s, f3_s};
                        state_s = READY;
                        busy_s  = 1'b0;
                        valid_s = 1'b1;
                    end else begin
                        state_s = EXPAND;
                    end
                end
                READY: begin
                    if (rk_rewind) begin
                        rk_s    = k10_r;
                        round_s = 4'(NR);
                    end else if (rk_req && (rk_round != 4'd0)) begin
                        rk_s    = {i0_s, i1_s, i2_s, i3_s};
                        round_s = rk_round - 4'd1;
                    end else begin
                        rk_s    = rk_out;
                    end
                end
                default: begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    valid_s = 1'b0;
                end
            endcase
        end
        last_s = valid_s && (round_s == 4'd0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            k10_r    <= {KW{1'b0}};
            rk_out   <= {KW{1'b0}};
            rk_round <= 4'd0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
        end else begin
            state_r  <= state_s;
            k10_r    <= k10_s;
            rk_out   <= rk_s;
            rk_round <= round_s;
            busy     <= busy_s;
            rk_valid <= valid_s;
            rk_last  <= last_s;
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;
    import aes_pkg::*;

    logic          clk;
    logic          rst;
    logic          key_load;
    logic [KW-1:0] key_in;
    logic          rk_req;
    logic          rk_rewind;
    logic          busy;
    logic          rk_valid;
    logic [KW-1:0] rk_out;
    logic [3:0]    rk_round;
    logic          rk_last;

    int checks;
    int failures;
    int n;

    localparam logic [127:0] KEY_A   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_A10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B1  = 128'ha0fafe1788542cb123a339392a6c7605;

    aes_inv_key_sched dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .rk_req(rk_req), .rk_rewind(rk_rewind), .busy(busy),
        .rk_valid(rk_valid), .rk_out(rk_out), .rk_round(rk_round),
        .rk_last(rk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Counts edges until busy drops (bounded).
    task automatic wait_expand(output int cycles);
        cycles = 0;
        while (busy && cycles < 50) begin
            tick();
            cycles = cycles + 1;
        end
    endtask

    task automatic req_n(input int count);
        for (int i = 0; i < count; i++) begin
            rk_req = 1'b1;
            tick();
        end
        rk_req = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        rk_req    = 1'b0;
        rk_rewind = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        chk("rst_busy",  128'(busy),     128'd0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_out",   rk_out,         128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        chk("rst_last",  128'(rk_last),  128'd0);

        // Key A: expansion length and round-10 key.
        load_key(KEY_A);
        chk("a_busy_start",  128'(busy),     128'd1);
        chk("a_valid_start", 128'(rk_valid), 128'd0);
        wait_expand(n);
        chk("a_busy_cycles", 128'(n),        128'd10);
        chk("a_valid",       128'(rk_valid), 128'd1);
        chk("a_round",       128'(rk_round), 128'd10);
        chk("a_k10",         rk_out,         KEY_A10);

        // Key B loaded from READY: walk down to round 0.
        load_key(KEY_B);
        wait_expand(n);
        chk("b_busy_cycles", 128'(n),       128'd10);
        chk("b_k10",         rk_out,        KEY_B10);
        chk("b_last10",      128'(rk_last), 128'd0);
        req_n(9);
        chk("b_round1", 128'(rk_round), 128'd1);
        chk("b_k1",     rk_out,         KEY_B1);
        chk("b_last1",  128'(rk_last),  128'd0);
        req_n(1);
        chk("b_round0", 128'(rk_round), 128'd0);
        chk("b_k0",     rk_out,         KEY_B);
        chk("b_last0",  128'(rk_last),  128'd1);
        req_n(1);
        chk("b_hold_round", 128'(rk_round), 128'd0);
        chk("b_hold_key",   rk_out,         KEY_B);
        chk("b_hold_valid", 128'(rk_valid), 128'd1);

        // Rewind from round 0, descend to 3, then rewind with req together.
        rk_rewind = 1'b1;
        tick();
        rk_rewind = 1'b0;
        chk("rw0_round", 128'(rk_round), 128'd10);
        chk("rw0_key",   rk_out,         KEY_B10);
        req_n(7);
        chk("rw_round3", 128'(rk_round), 128'd3);
        rk_rewind = 1'b1;
        rk_req    = 1'b1;
        tick();
        rk_rewind = 1'b0;
        rk_req    = 1'b0;
        chk("rw_round", 128'(rk_round), 128'd10);
        chk("rw_key",   rk_out,         KEY_B10);
        chk("rw_busy",  128'(busy),     128'd0);
        chk("rw_valid", 128'(rk_valid), 128'd1);

        // Abort mid-expansion with a new key.
        load_key(KEY_B);
        repeat (5) tick();
        chk("ab_mid_round", 128'(rk_round), 128'd5);
        chk("ab_mid_busy",  128'(busy),     128'd1);
        rk_req = 1'b1;
        load_key(KEY_A);
        rk_req = 1'b0;
        chk("ab_round0", 128'(rk_round), 128'd0);
        wait_expand(n);
        chk("ab_busy_cycles", 128'(n),        128'd10);
        chk("ab_k10",         rk_out,         KEY_A10);
        chk("ab_round",       128'(rk_round), 128'd10);

        // Asynchronous reset between edges while READY.
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 128'(rk_valid), 128'd0);
        chk("ar_out",   rk_out,         128'd0);
        chk("ar_round", 128'(rk_round), 128'd0);
        chk("ar_busy",  128'(busy),     128'd0);
        #2;
        rst = 1'b0;
        req_n(1);
        chk("ar_req_round", 128'(rk_round), 128'd0);
        chk("ar_req_out",   rk_out,         128'd0);
        chk("ar_req_valid", 128'(rk_valid), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
